// File: rtl/pulse_pair_checker.sv
// Clocked monitor comparing two nominally identical signals; counts mismatches and a_i rises, latches a sticky fail.
// Optional build macro: PULSE_PAIR_CHK_STOP_EN (report and stop the simulation on entry to FAIL).
module pulse_pair_checker #(
    parameter int CNT_W        = 8,
    parameter int WARMUP       = 2,
    parameter int MAX_MISMATCH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic [CNT_W-1:0] a_pulses_o,
    output logic [CNT_W-1:0] first_fail_cyc_o,
    output logic             fail_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'b00,
        ST_CHECK  = 2'b01,
        ST_FAIL   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP == 0) ? '0 : CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] MAX_THR   = CNT_W'(MAX_MISMATCH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, idx_q;
    logic             a_q, b_q, en_q, vld_q, prev_a_q;
    logic [CNT_W-1:0] mm_cnt_q, pulses_q, first_q;
    logic             mm_q;

    logic             counted;
    logic             rise;
    logic [CNT_W-1:0] mm_cnt_inc;

    // en_i is a sample qualifier, not a handshake: there is no back-pressure.
    // vld_q marks that stage 1 holds a real sample; edge 0 after reset evaluates nothing.
    always_comb begin
        counted    = vld_q && en_q && (a_q !== b_q) && (int'(idx_q) >= WARMUP)
                     && (state_q != ST_FAIL);
        rise       = vld_q && (state_q == ST_CHECK) && a_q && !prev_a_q;
        mm_cnt_inc = (mm_cnt_q == CNT_MAX) ? mm_cnt_q : mm_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WARMUP: if (vld_q && idx_q == WARM_LAST) state_d = ST_CHECK;
            ST_CHECK:  state_d = ST_CHECK;
            ST_FAIL:   state_d = ST_FAIL;
            default:   state_d = ST_WARMUP;
        endcase
        // Threshold hit wins over the warmup exit (only reachable with WARMUP=0).
        if (counted && mm_cnt_inc >= MAX_THR) state_d = ST_FAIL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_WARMUP;
            cyc_q    <= '0;
            idx_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            en_q     <= 1'b0;
            vld_q    <= 1'b0;
            prev_a_q <= 1'b0;
            mm_cnt_q <= '0;
            pulses_q <= '0;
            first_q  <= '0;
            mm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_W'(1);
            idx_q    <= cyc_q;
            a_q      <= a_i;
            b_q      <= b_i;
            en_q     <= en_i;
            vld_q    <= 1'b1;
            prev_a_q <= a_q;
            mm_q     <= counted;
            if (counted) begin
                mm_cnt_q <= mm_cnt_inc;
                if (mm_cnt_q == '0) first_q <= idx_q;
            end
            if (rise) pulses_q <= (pulses_q == CNT_MAX) ? pulses_q : pulses_q + CNT_W'(1);
        end
    end

    assign mismatch_o       = mm_q;
    assign mismatch_cnt_o   = mm_cnt_q;
    assign a_pulses_o       = pulses_q;
    assign first_fail_cyc_o = first_q;
    assign fail_o           = (state_q == ST_FAIL);
    assign state_o          = state_q;

`ifdef PULSE_PAIR_CHK_STOP_EN
    always_ff @(posedge clk) begin
        if (rst_n && state_q != ST_FAIL && state_d == ST_FAIL) begin
            $error("pulse_pair_checker: fail at sample %0d",
                   (mm_cnt_q == '0) ? idx_q : first_q);
            $stop;
        end
    end
`else
    // Fail is reported only through fail_o and state_o.
`endif

endmodule

// File: tb/tb_pulse_pair_checker.sv
// Randomized bench for pulse_pair_checker: two instances (normal and small-width saturating)
// checked against a history-based reference model.
module tb_pulse_pair_checker;

    localparam int M_CW = 5, M_WARM = 2, M_MAX = 4;
    localparam int S_CW = 4, S_WARM = 0, S_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_i = 1'b0, a_i = 1'b0, b_i = 1'b0;

    logic            m_mm, m_fail, s_mm, s_fail;
    logic [M_CW-1:0] m_cnt, m_pul, m_first;
    logic [S_CW-1:0] s_cnt, s_pul, s_first;
    logic [1:0]      m_st, s_st;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;
    bit a_h[$], b_h[$], e_h[$];

    // ---- clock / reset
    always #5 clk = ~clk;

    pulse_pair_checker #(.CNT_W(M_CW), .WARMUP(M_WARM), .MAX_MISMATCH(M_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .a_i(a_i), .b_i(b_i),
        .mismatch_o(m_mm), .mismatch_cnt_o(m_cnt), .a_pulses_o(m_pul),
        .first_fail_cyc_o(m_first), .fail_o(m_fail), .state_o(m_st));

    pulse_pair_checker #(.CNT_W(S_CW), .WARMUP(S_WARM), .MAX_MISMATCH(S_MAX)) u_sat (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .a_i(a_i), .b_i(b_i),
        .mismatch_o(s_mm), .mismatch_cnt_o(s_cnt), .a_pulses_o(s_pul),
        .first_fail_cyc_o(s_first), .fail_o(s_fail), .state_o(s_st));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: replays the whole sample history since reset
    function automatic void model(input int n, input int cw, input int warm, input int maxm,
                                  output int cnt, output int pul, output int first,
                                  output int st, output int mo);
        int top;
        int idx;
        int first_check;
        bit failed;
        bit prev;
        top = (1 << cw) - 1;
        first_check = (warm == 0) ? 1 : warm;
        cnt = 0; pul = 0; first = 0; mo = 0;
        failed = 1'b0; prev = 1'b0;
        for (int k = 0; k < n; k++) begin
            idx = (k < top) ? k : top;
            mo = 0;
            if (!failed) begin
                if (k >= first_check && a_h[k] && !prev) pul = (pul < top) ? pul + 1 : top;
                if (a_h[k] != b_h[k] && e_h[k] && idx >= warm) begin
                    if (cnt == 0) first = idx;
                    cnt = (cnt < top) ? cnt + 1 : top;
                    mo = 1;
                    if (cnt >= maxm) failed = 1'b1;
                end
            end
            prev = a_h[k];
        end
        st = failed ? 2 : ((n >= first_check) ? 1 : 0);
    endfunction

    // ---- scoreboard
    task automatic check_outputs();
        int n, cnt, pul, first, st, mo;
        n = (edges > 0) ? edges - 1 : 0;
        model(n, M_CW, M_WARM, M_MAX, cnt, pul, first, st, mo);
        check("m_mismatch", 32'(m_mm), mo);
        check("m_cnt", 32'(m_cnt), cnt);
        check("m_pulses", 32'(m_pul), pul);
        check("m_first", 32'(m_first), first);
        check("m_fail", 32'(m_fail), (st == 2) ? 1 : 0);
        check("m_state", 32'(m_st), st);
        model(n, S_CW, S_WARM, S_MAX, cnt, pul, first, st, mo);
        check("s_mismatch", 32'(s_mm), mo);
        check("s_cnt", 32'(s_cnt), cnt);
        check("s_pulses", 32'(s_pul), pul);
        check("s_first", 32'(s_first), first);
        check("s_fail", 32'(s_fail), (st == 2) ? 1 : 0);
        check("s_state", 32'(s_st), st);
    endtask

    // ---- drivers (each starts and ends on a falling edge)
    task automatic reset_dut();
        #3 rst_n = 1'b0;
        a_h.delete(); b_h.delete(); e_h.delete();
        edges = 0;
        #1 check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int mode);
        int k;
        k = a_h.size();
        case (mode)
            0: begin a_i = ((k / 2) % 2 == 1); b_i = a_i; en_i = 1'b1; end
            1: begin
                a_i  = 1'($urandom_range(0, 1));
                b_i  = a_i ^ ($urandom_range(0, 5) == 0);
                en_i = ($urandom_range(0, 3) != 0);
            end
            default: begin a_i = 1'($urandom_range(0, 1)); b_i = !a_i; en_i = 1'b1; end
        endcase
        a_h.push_back(a_i);
        b_h.push_back(b_i);
        e_h.push_back(en_i);
        @(posedge clk);
        edges++;
        #1 check_outputs();
        @(negedge clk);
    endtask

    initial begin
        int modes[7] = '{0, 1, 2, 1, 2, 1, 1};
        @(negedge clk);
        reset_dut();
        for (int s = 0; s < 7; s++) begin
            for (int i = 0; i < 40; i++) step(modes[s]);
            reset_dut();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
